// File: rtl/rgb_pkg.sv
// rgb_pkg: mode/breathe encodings and switch-code colour table for the RGB PWM driver
package rgb_pkg;
   typedef enum logic [1:0] {
      MODE_STATIC  = 2'b00,
      MODE_BLINK   = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_OFF     = 2'b11
   } mode_t;
   typedef enum logic {RAMP_UP = 1'b0, RAMP_DOWN = 1'b1} ramp_dir_t;
   localparam logic [2:0] COL_00 = 3'b111;
   localparam logic [2:0] COL_01 = 3'b100;
   localparam logic [2:0] COL_10 = 3'b010;
   localparam logic [2:0] COL_11 = 3'b110;
   function automatic logic [2:0] sw_colour(input logic [1:0] code);
      return code == 2'b00 ? COL_00 : code == 2'b01 ? COL_01 : code == 2'b10 ? COL_10 : COL_11;
   endfunction
endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: per-LED switch synchroniser, period-latched colour and registered PWM gate
module rgb_pwm_channel
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          sw,
   input  logic                start,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic [PWM_BITS-1:0] duty,
   output logic [2:0]          rgb
);
   logic [1:0] sync1, sync2;
   logic [2:0] col_l, col;
   // the period-start cycle already uses the freshly latched colour
   assign col = start ? sw_colour(sync2) : col_l;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         col_l <= '0;
         rgb   <= '0;
      end else begin
         sync1 <= sw;
         sync2 <= sync1;
         if (start) col_l <= col;
         rgb <= col & {3{pwm_cnt < duty}};
      end
   end
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: multi-channel RGB PWM driver with static/blink/breathe/off modes.
// Define GAMMA_EN for squared (gamma) duty mapping; default is linear duty.
module rgb_pwm_ctrl
   import rgb_pkg::*;
#(
   parameter int CH        = 1,
   parameter int PWM_BITS  = 8,
   parameter int BLINK_DIV = 100,
   parameter int RAMP_DIV  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2*CH-1:0]     sw,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] bright,
   output logic [3*CH-1:0]     rgb
);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam int RW = $clog2(RAMP_DIV + 1);
   localparam logic [PWM_BITS-1:0] P = '1;
   localparam logic [PWM_BITS-1:0] P_LAST = P - 1'b1;
   localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV);
   localparam logic [RW-1:0] RAMP_END = RW'(RAMP_DIV);
   logic [PWM_BITS-1:0] pwm_cnt, duty_l, ramp, ramp_n, duty, duty_g, duty_eff;
   logic [BW-1:0] blink_cnt, blink_n, blink_inc;
   logic [RW-1:0] ramp_cnt, ramp_cnt_n, rc_inc;
   mode_t mode_l, mode_n;
   ramp_dir_t dir, dir_n;
   logic phase, phase_n, start, enter_blink, enter_breathe, step;
   assign start = pwm_cnt == '0;
   assign mode_n = mode_t'(mode);
   assign enter_blink = mode_n == MODE_BLINK && mode_l != MODE_BLINK;
   assign enter_breathe = mode_n == MODE_BREATHE && mode_l != MODE_BREATHE;
   assign blink_inc = blink_cnt + 1'b1;
   assign rc_inc = ramp_cnt + 1'b1;
   assign step = rc_inc == RAMP_END;
   always_comb begin
      phase_n = enter_blink ? 1'b1 : (mode_n == MODE_BLINK && blink_inc == BLINK_END) ? ~phase : phase;
      blink_n = enter_blink ? '0 : mode_n != MODE_BLINK ? blink_cnt : blink_inc == BLINK_END ? '0 : blink_inc;
   end
   // breathe ramp: saturating triangle between 0 and the current brightness
   always_comb begin
      ramp_n = ramp;
      dir_n = dir;
      ramp_cnt_n = ramp_cnt;
      if (enter_breathe) begin
         ramp_n = '0;
         dir_n = RAMP_UP;
         ramp_cnt_n = '0;
      end else if (mode_n == MODE_BREATHE) begin
         ramp_cnt_n = step ? '0 : rc_inc;
         if (ramp > bright) begin
            ramp_n = bright;
            dir_n = RAMP_DOWN;
         end else if (step && dir == RAMP_UP) begin
            if (ramp < bright) ramp_n = ramp + 1'b1;
            dir_n = ramp_n == bright ? RAMP_DOWN : RAMP_UP;
         end else if (step) begin
            if (ramp != '0) ramp_n = ramp - 1'b1;
            dir_n = ramp_n == '0 ? RAMP_UP : RAMP_DOWN;
         end
      end
   end
   always_comb begin
      duty = mode_n == MODE_STATIC ? bright :
             mode_n == MODE_BLINK ? (phase_n ? bright : '0) :
             mode_n == MODE_BREATHE ? (ramp_n < bright ? ramp_n : bright) : '0;
   end
`ifdef GAMMA_EN
   logic [2*PWM_BITS-1:0] sq;
   assign sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
   assign duty_g = duty == P ? P : sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty_g = duty;
`endif
   assign duty_eff = start ? duty_g : duty_l;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt   <= '0;
         duty_l    <= '0;
         mode_l    <= MODE_STATIC;
         phase     <= 1'b1;
         blink_cnt <= '0;
         ramp      <= '0;
         ramp_cnt  <= '0;
         dir       <= RAMP_UP;
      end else begin
         pwm_cnt <= pwm_cnt == P_LAST ? '0 : pwm_cnt + 1'b1;
         if (start) begin
            duty_l    <= duty_g;
            mode_l    <= mode_n;
            phase     <= phase_n;
            blink_cnt <= blink_n;
            ramp      <= ramp_n;
            ramp_cnt  <= ramp_cnt_n;
            dir       <= dir_n;
         end
      end
   end
   for (genvar k = 0; k < CH; k++) begin : g_ch
      rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw     (sw[2*k+1:2*k]),
         .start  (start),
         .pwm_cnt(pwm_cnt),
         .duty   (duty_eff),
         .rgb    (rgb[3*k+2:3*k])
      );
   end
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: scoreboard bench for rgb_pwm_ctrl with CH=2, 4-bit PWM (P=15 clocks)
module tb_rgb_pwm_ctrl;
   localparam int N = 4;
   localparam int P = 15;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] sw = 4'b0001;
   logic [1:0] mode = 2'b00;
   logic [3:0] bright = 4'd15;
   logic [5:0] rgb;
   logic [5:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   rgb_pwm_ctrl #(.CH(2), .PWM_BITS(N), .BLINK_DIV(2), .RAMP_DIV(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw),
      .mode  (mode),
      .bright(bright),
      .rgb   (rgb)
   );
   function automatic int gam(input int d);
`ifdef GAMMA_EN
      return d == P ? P : (d * d) >> N;
`else
      return d;
`endif
   endfunction
   // one PWM period: expected words queued up front, popped one per output cycle
   task automatic run_period(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                             input int duty, input int sw_at = -1, input logic [3:0] sw_new = 4'b0);
      int on;
      logic [5:0] exp;
      on = gam(duty);
      for (int i = 0; i < P; i++) exp_q.push_back(i < on ? {c1, c0} : 6'b0);
      for (int i = 0; i < P; i++) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (rgb !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d rgb=%b expected=%b", tag, i, rgb, exp);
         end
         if (i == sw_at) sw = sw_new;
      end
   endtask
   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold rgb=%b expected=000000", rgb);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_period("reset_first", 3'b111, 3'b111, 15);
      run_period("reset_colour", 3'b100, 3'b111, 15);
      run_period("reset_colour", 3'b100, 3'b111, 15);
   endtask
   task automatic test_static;
      sw = 4'b0011;
      bright = 4'd5;
      run_period("static_old_col", 3'b100, 3'b111, 5);
      run_period("static_5", 3'b110, 3'b111, 5);
      run_period("static_5", 3'b110, 3'b111, 5);
      bright = 4'd0;
      run_period("static_0", 3'b110, 3'b111, 0);
      bright = 4'd15;
      run_period("static_full", 3'b110, 3'b111, 15);
      bright = 4'd8;
      run_period("static_8", 3'b110, 3'b111, 8);
   endtask
   task automatic test_sw_mid;
      bright = 4'd15;
      run_period("sw_mid_hold", 3'b110, 3'b111, 15, 5, 4'b1001);
      run_period("sw_mid_new", 3'b100, 3'b010, 15);
   endtask
   task automatic test_blink;
      int seq[6] = '{15, 15, 0, 0, 15, 15};
      mode = 2'b01;
      bright = 4'd15;
      for (int i = 0; i < 6; i++) run_period("blink", 3'b100, 3'b010, seq[i]);
   endtask
   task automatic test_breathe;
      int seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      mode = 2'b10;
      bright = 4'd3;
      for (int i = 0; i < 8; i++) run_period("breathe", 3'b100, 3'b010, seq[i]);
   endtask
   task automatic test_reset_mid;
      @(posedge clk);
      #1;
      checks++;
      if (rgb !== (gam(2) > 0 ? 6'b010100 : 6'b0)) begin
         errors++;
         $display("FAIL pre_reset_on rgb=%b expected=%b", rgb, gam(2) > 0 ? 6'b010100 : 6'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (rgb !== 6'b0) begin
         errors++;
         $display("FAIL reset_async rgb=%b expected=000000", rgb);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_period("reset_mid_p0", 3'b111, 3'b111, 0);
      run_period("reset_mid_p1", 3'b100, 3'b010, 1);
      run_period("reset_mid_p2", 3'b100, 3'b010, 2);
   endtask
   task automatic test_off;
      mode = 2'b11;
      bright = 4'd15;
      run_period("off", 3'b100, 3'b010, 0);
      run_period("off", 3'b100, 3'b010, 0);
      mode = 2'b00;
      run_period("off_to_static", 3'b100, 3'b010, 15);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      test_reset();
      test_static();
      test_sw_mid();
      test_blink();
      test_breathe();
      test_reset_mid();
      test_off();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
